uart_mvm_system: RTL and testbench



---
 rtl/uart_mvm_system_if.sv | 12 +
 rtl/uart_mvm_system.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_uart_mvm_system.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_mvm_system_if.sv
// Pin bundle of the Tiny Tapeout-style wrapper: master drives the inputs, slave drives the outputs.
interface uart_mvm_system_if;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic       ena;

  modport master (output ui_in, uio_in, ena, input uo_out, uio_out, uio_oe);
  modport slave  (input ui_in, uio_in, ena, output uo_out, uio_out, uio_oe);
endinterface

// File: rtl/uart_mvm_system.sv
// UART-fed signed matrix-vector multiplier (Y = K*X) returning Y over UART TX.
// Optional macro UART_RX_SYNC_EN adds a 2-flop synchronizer on the RX pin.
module tt_um_uart_mvm #(
  parameter int unsigned CLOCKS_PER_PULSE = 4,
  parameter int unsigned BITS_PER_WORD    = 8,
  parameter int unsigned PACKET_SIZE_TX   = 13,
  parameter int unsigned R                = 4,
  parameter int unsigned C                = 4,
  parameter int unsigned W_X              = 4,
  parameter int unsigned W_K              = 2,
  parameter int unsigned W_Y_OUT          = 8
) (
  input logic                clk,
  input logic                rst,
  uart_mvm_system_if.slave   pins
);
  localparam int unsigned W_Y        = W_X + W_K + $clog2(C);
  localparam int unsigned W_BUS_KX   = R * C * W_K + C * W_X;
  localparam int unsigned W_BUS_Y    = R * W_Y_OUT;
  localparam int unsigned N_WORDS_KX = W_BUS_KX / BITS_PER_WORD;
  localparam int unsigned N_WORDS_Y  = W_BUS_Y / BITS_PER_WORD;
  localparam int unsigned W_BAUD     = $clog2(CLOCKS_PER_PULSE + 1);
  localparam int unsigned W_RXBIT    = $clog2(BITS_PER_WORD + 1);
  localparam int unsigned W_TXBIT    = $clog2(PACKET_SIZE_TX + 1);
  localparam int unsigned W_KXCNT    = $clog2(N_WORDS_KX + 1);
  localparam int unsigned W_YCNT     = $clog2(N_WORDS_Y + 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic       {TX_IDLE, TX_SEND} tx_state_e;

  logic rx_s;
  logic unused_pins;

  rx_state_e                rx_state_q, rx_state_d;
  logic [W_BAUD-1:0]        rx_baud_q, rx_baud_d;
  logic [W_RXBIT-1:0]       rx_bit_q, rx_bit_d;
  logic [BITS_PER_WORD-1:0] rx_data_q, rx_data_d;
  logic [W_KXCNT-1:0]       byte_cnt_q, byte_cnt_d;
  logic [W_BUS_KX-1:0]      bus_kx_q, bus_kx_d;
  logic                     frame_done_q, frame_done_d;

  logic [W_BUS_Y-1:0]       y_bus_c;
  logic [W_BUS_Y-1:0]       out_q;
  logic                     pending_q, pending_d;

  tx_state_e                tx_state_q, tx_state_d;
  logic [W_BAUD-1:0]        tx_baud_q, tx_baud_d;
  logic [W_TXBIT-1:0]       tx_bit_q, tx_bit_d;
  logic [W_YCNT-1:0]        tx_byte_q, tx_byte_d;
  logic [W_BUS_Y-1:0]       tx_buf_q, tx_buf_d;
  logic                     tx_q, tx_d;
  logic                     tx_load_c;
  logic [BITS_PER_WORD-1:0] tx_cur_c, tx_shift_c;

  assign unused_pins = ^{pins.ena, pins.uio_in, pins.ui_in[7:1]};

`ifdef UART_RX_SYNC_EN
  logic [1:0] rx_sync_q;
  always_ff @(posedge clk) begin
    if (rst) rx_sync_q <= 2'b11;
    else     rx_sync_q <= {rx_sync_q[0], pins.ui_in[0]};
  end
  assign rx_s = rx_sync_q[1];
`else
  assign rx_s = pins.ui_in[0];
`endif

  // RX: mid-bit sampling, stop bit must be high for the byte to be kept
  always_comb begin
    rx_state_d   = rx_state_q;
    rx_baud_d    = rx_baud_q;
    rx_bit_d     = rx_bit_q;
    rx_data_d    = rx_data_q;
    byte_cnt_d   = byte_cnt_q;
    bus_kx_d     = bus_kx_q;
    frame_done_d = 1'b0;
    unique case (rx_state_q)
      RX_IDLE: begin
        if (!rx_s) begin
          rx_state_d = RX_START;
          rx_baud_d  = '0;
        end
      end
      RX_START: begin
        if (rx_baud_q == W_BAUD'(CLOCKS_PER_PULSE / 2 - 1)) begin
          rx_baud_d  = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_s ? RX_IDLE : RX_DATA;
        end else begin
          rx_baud_d = rx_baud_q + W_BAUD'(1);
        end
      end
      RX_DATA: begin
        if (rx_baud_q == W_BAUD'(CLOCKS_PER_PULSE - 1)) begin
          rx_baud_d = '0;
          rx_data_d = {rx_s, rx_data_q[BITS_PER_WORD-1:1]};
          if (rx_bit_q == W_RXBIT'(BITS_PER_WORD - 1)) rx_state_d = RX_STOP;
          else rx_bit_d = rx_bit_q + W_RXBIT'(1);
        end else begin
          rx_baud_d = rx_baud_q + W_BAUD'(1);
        end
      end
      RX_STOP: begin
        if (rx_baud_q == W_BAUD'(CLOCKS_PER_PULSE - 1)) begin
          rx_state_d = RX_IDLE;
          if (rx_s) begin
            bus_kx_d[int'(byte_cnt_q) * BITS_PER_WORD +: BITS_PER_WORD] = rx_data_q;
            if (byte_cnt_q == W_KXCNT'(N_WORDS_KX - 1)) begin
              byte_cnt_d   = '0;
              frame_done_d = 1'b1;
            end else begin
              byte_cnt_d = byte_cnt_q + W_KXCNT'(1);
            end
          end
        end else begin
          rx_baud_d = rx_baud_q + W_BAUD'(1);
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Signed MVM, accumulated at W_Y bits where overflow cannot occur
  always_comb begin
    logic signed [W_X-1:0] x_v;
    logic signed [W_K-1:0] k_v;
    logic signed [W_Y-1:0] acc;
    y_bus_c = '0;
    x_v     = '0;
    k_v     = '0;
    acc     = '0;
    for (int r = 0; r < R; r++) begin
      acc = '0;
      for (int c = 0; c < C; c++) begin
        x_v = bus_kx_q[W_X * c +: W_X];
        k_v = bus_kx_q[C * W_X + (r * C + c) * W_K +: W_K];
        acc = acc + W_Y'(k_v) * W_Y'(x_v);
      end
      y_bus_c[r * W_Y_OUT +: W_Y_OUT] = W_Y_OUT'(acc);
    end
  end

  // A fresh result always wins over the clear from a TX load in the same cycle
  always_comb begin
    pending_d = pending_q;
    if (tx_load_c)    pending_d = 1'b0;
    if (frame_done_q) pending_d = 1'b1;
  end

  assign tx_cur_c   = tx_buf_q[int'(tx_byte_q) * BITS_PER_WORD +: BITS_PER_WORD];
  assign tx_shift_c = tx_cur_c >> tx_bit_q;

  // TX: frame = start, data LSB first, then high padding up to PACKET_SIZE_TX bits
  always_comb begin
    tx_state_d = tx_state_q;
    tx_baud_d  = tx_baud_q;
    tx_bit_d   = tx_bit_q;
    tx_byte_d  = tx_byte_q;
    tx_buf_d   = tx_buf_q;
    tx_d       = tx_q;
    tx_load_c  = 1'b0;
    unique case (tx_state_q)
      TX_IDLE: begin
        tx_d = 1'b1;
        if (pending_q) begin
          tx_state_d = TX_SEND;
          tx_buf_d   = out_q;
          tx_baud_d  = '0;
          tx_bit_d   = '0;
          tx_byte_d  = '0;
          tx_d       = 1'b0;
          tx_load_c  = 1'b1;
        end
      end
      TX_SEND: begin
        if (tx_baud_q == W_BAUD'(CLOCKS_PER_PULSE - 1)) begin
          tx_baud_d = '0;
          if (tx_bit_q == W_TXBIT'(PACKET_SIZE_TX - 1)) begin
            tx_bit_d = '0;
            if (tx_byte_q == W_YCNT'(N_WORDS_Y - 1)) begin
              tx_state_d = TX_IDLE;
              tx_d       = 1'b1;
            end else begin
              tx_byte_d = tx_byte_q + W_YCNT'(1);
              tx_d      = 1'b0;
            end
          end else begin
            tx_bit_d = tx_bit_q + W_TXBIT'(1);
            tx_d     = (int'(tx_bit_q) < BITS_PER_WORD) ? tx_shift_c[0] : 1'b1;
          end
        end else begin
          tx_baud_d = tx_baud_q + W_BAUD'(1);
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q   <= RX_IDLE;
      rx_baud_q    <= '0;
      rx_bit_q     <= '0;
      rx_data_q    <= '0;
      byte_cnt_q   <= '0;
      bus_kx_q     <= '0;
      frame_done_q <= 1'b0;
      out_q        <= '0;
      pending_q    <= 1'b0;
      tx_state_q   <= TX_IDLE;
      tx_baud_q    <= '0;
      tx_bit_q     <= '0;
      tx_byte_q    <= '0;
      tx_buf_q     <= '0;
      tx_q         <= 1'b1;
    end else begin
      rx_state_q   <= rx_state_d;
      rx_baud_q    <= rx_baud_d;
      rx_bit_q     <= rx_bit_d;
      rx_data_q    <= rx_data_d;
      byte_cnt_q   <= byte_cnt_d;
      bus_kx_q     <= bus_kx_d;
      frame_done_q <= frame_done_d;
      if (frame_done_q) out_q <= y_bus_c;
      pending_q    <= pending_d;
      tx_state_q   <= tx_state_d;
      tx_baud_q    <= tx_baud_d;
      tx_bit_q     <= tx_bit_d;
      tx_byte_q    <= tx_byte_d;
      tx_buf_q     <= tx_buf_d;
      tx_q         <= tx_d;
    end
  end

  assign pins.uo_out  = {7'b0, tx_q};
  assign pins.uio_out = 8'h00;
  assign pins.uio_oe  = 8'h00;
endmodule

module uart_mvm_system #(
  parameter int unsigned CLOCKS_PER_PULSE = 4,
  parameter int unsigned BITS_PER_WORD    = 8,
  parameter int unsigned PACKET_SIZE_TX   = 13,
  parameter int unsigned R                = 4,
  parameter int unsigned C                = 4,
  parameter int unsigned W_X              = 4,
  parameter int unsigned W_K              = 2,
  parameter int unsigned W_Y_OUT          = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena
);
  uart_mvm_system_if pins ();

  assign pins.ui_in  = ui_in;
  assign pins.uio_in = uio_in;
  assign pins.ena    = ena;
  assign uo_out      = pins.uo_out;
  assign uio_out     = pins.uio_out;
  assign uio_oe      = pins.uio_oe;

  tt_um_uart_mvm #(
    .CLOCKS_PER_PULSE(CLOCKS_PER_PULSE),
    .BITS_PER_WORD   (BITS_PER_WORD),
    .PACKET_SIZE_TX  (PACKET_SIZE_TX),
    .R               (R),
    .C               (C),
    .W_X             (W_X),
    .W_K             (W_K),
    .W_Y_OUT         (W_Y_OUT)
  ) u_core (
    .clk (clk),
    .rst (rst),
    .pins(pins)
  );
endmodule

// File: tb/tb_uart_mvm_system.sv
// Bench for uart_mvm_system: drives UART words, decodes the TX line and compares with a software MVM.
module tb_uart_mvm_system;
  localparam int unsigned CPP = 4;
`ifdef UART_RX_SYNC_EN
  localparam int unsigned LAT = 43;
`else
  localparam int unsigned LAT = 41;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_mvm_system_if bus ();

  uart_mvm_system dut (
    .clk    (clk),
    .rst    (rst),
    .ui_in  (bus.ui_in),
    .uo_out (bus.uo_out),
    .uio_in (bus.uio_in),
    .uio_out(bus.uio_out),
    .uio_oe (bus.uio_oe),
    .ena    (bus.ena)
  );

  int          errors = 0;
  int          checks = 0;
  int unsigned cyc = 0;
  int unsigned last_start_cyc = 0;
  int unsigned fall_cyc = 0;
  int unsigned fall_count = 0;
  bit          dec_busy = 1'b0;
  logic [7:0]  exp_q[$];
  logic [7:0]  part_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference MVM straight from the packing and arithmetic rules
  function automatic logic [31:0] mvm_model(input logic [47:0] w);
    int x[4];
    int k;
    int y;
    logic [31:0] res;
    for (int c = 0; c < 4; c++) begin
      x[c] = int'(w[4*c +: 4]);
      if (x[c] >= 8) x[c] -= 16;
    end
    res = '0;
    for (int r = 0; r < 4; r++) begin
      y = 0;
      for (int c = 0; c < 4; c++) begin
        k = int'(w[16 + 2*(4*r + c) +: 2]);
        if (k >= 2) k -= 4;
        y += k * x[c];
      end
      res[8*r +: 8] = 8'(y);
    end
    return res;
  endfunction

  task automatic model_rx(input logic [7:0] b);
    logic [47:0] w;
    logic [31:0] y;
    part_q.push_back(b);
    if (part_q.size() == 6) begin
      for (int i = 0; i < 6; i++) w[8*i +: 8] = part_q[i];
      y = mvm_model(w);
      for (int r = 0; r < 4; r++) exp_q.push_back(y[8*r +: 8]);
      part_q.delete();
    end
  endtask

  // Called on a falling edge; leaves the line idle high afterwards
  task automatic send_byte(input logic [7:0] b, input logic stop, input bit use_model);
    last_start_cyc = cyc;
    bus.ui_in[0] = 1'b0;
    repeat (CPP) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.ui_in[0] = b[i];
      repeat (CPP) @(negedge clk);
    end
    bus.ui_in[0] = stop;
    repeat (CPP) @(negedge clk);
    bus.ui_in[0] = 1'b1;
    if (stop && use_model) model_rx(b);
  endtask

  task automatic drain();
    for (int i = 0; i < 3000; i++) begin
      if (exp_q.size() == 0 && !dec_busy) break;
      @(negedge clk);
    end
    chk("drain_pending", 32'(exp_q.size()) + 32'(dec_busy), 32'd0);
  endtask

  task automatic directed(input logic [47:0] w, input logic [31:0] y, input bit check_lat);
    int unsigned c0;
    for (int r = 0; r < 4; r++) exp_q.push_back(y[8*r +: 8]);
    c0 = fall_count;
    for (int i = 0; i < 6; i++) send_byte(w[8*i +: 8], 1'b1, 1'b0);
    if (check_lat) begin
      for (int i = 0; i < 20; i++) begin
        if (fall_count != c0) break;
        @(negedge clk);
      end
      chk("tx_latency", fall_cyc - last_start_cyc, LAT);
    end
    drain();
    repeat (10) @(negedge clk);
  endtask

  // Compare process: static pins every cycle, TX frames decoded at mid-bit
  task automatic tick();
    @(negedge clk);
    chk("static_pins", {9'd0, bus.uo_out[7:1], bus.uio_out, bus.uio_oe}, 32'd0);
  endtask

  initial begin : decoder
    logic [7:0] got;
    forever begin
      tick();
      if (!rst && bus.uo_out[0] == 1'b0) begin
        fall_cyc = cyc;
        fall_count++;
        dec_busy = 1'b1;
        got = '0;
        repeat (2) tick();
        chk("tx_start_bit", 32'(bus.uo_out[0]), 32'd0);
        for (int j = 1; j < 13; j++) begin
          repeat (CPP) tick();
          if (j <= 8) got[j-1] = bus.uo_out[0];
          else chk("tx_pad_bit", 32'(bus.uo_out[0]), 32'd1);
        end
        if (exp_q.size() == 0) chk("tx_unexpected_byte", 32'(got), 32'hFFFF_FFFF);
        else chk("tx_byte", 32'(got), 32'(exp_q.pop_front()));
        dec_busy = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit (errors=%0d)", errors);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int gap;
    bus.ui_in  = 8'hA5;
    bus.uio_in = 8'h5A;
    bus.ena    = 1'b1;
    rst        = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_tx", 32'(bus.uo_out[0]), 32'd1);
    chk("reset_uo_hi", 32'(bus.uo_out[7:1]), 32'd0);
    chk("reset_uio_out", 32'(bus.uio_out), 32'd0);
    chk("reset_uio_oe", 32'(bus.uio_oe), 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("idle_tx", 32'(bus.uo_out[0]), 32'd1);

    chk("model_x1_k1", mvm_model(48'h5555_5555_1111), 32'h0404_0404);
    chk("model_xm8_km2", mvm_model(48'hAAAA_AAAA_8888), 32'h4040_4040);
    chk("model_x7_km2", mvm_model(48'hAAAA_AAAA_7777), 32'hC8C8_C8C8);
    chk("model_mixed", mvm_model(48'hFFD0_0401_F321), 32'hFB04_0201);

    directed(48'h5555_5555_1111, 32'h0404_0404, 1'b1);
    directed(48'hAAAA_AAAA_8888, 32'h4040_4040, 1'b0);
    directed(48'hAAAA_AAAA_7777, 32'hC8C8_C8C8, 1'b0);
    directed(48'hFFD0_0401_F321, 32'hFB04_0201, 1'b0);

    // Framing error byte must be discarded without advancing the byte count
    send_byte(8'h3C, 1'b0, 1'b0);
    repeat (8) @(negedge clk);
    directed(48'h5555_5555_1111, 32'h0404_0404, 1'b0);

    // Reset after a partial word: only the following word produces a result
    send_byte(8'h77, 1'b1, 1'b0);
    send_byte(8'h77, 1'b1, 1'b0);
    send_byte(8'hAA, 1'b1, 1'b0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("midreset_tx", 32'(bus.uo_out[0]), 32'd1);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    directed(48'h5555_5555_1111, 32'h0404_0404, 1'b0);

    for (int n = 0; n < 10; n++) begin
      gap = int'($urandom_range(1, 100));
      repeat (gap) @(negedge clk);
      for (int i = 0; i < 6; i++) send_byte(8'($urandom), 1'b1, 1'b1);
    end
    drain();
    repeat (100) @(negedge clk);
    chk("end_tx_idle", 32'(bus.uo_out[0]), 32'd1);
    chk("end_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
